// File: rtl/mii_rx_framer.sv
// mii_rx_framer: MII/RMII receive front end.
// Oversamples the PHY, strips preamble/SFD, emits framed bytes.
`timescale 1ns/1ps
module mii_rx_framer #(
  parameter int MII_WIDTH       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mii_rx_clock,
  input  logic                     mii_rx_data_valid,
  input  logic                     mii_rx_error,
  input  logic [MII_WIDTH-1:0]     mii_rx_data,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     out_error,
  output logic [COUNTER_WIDTH-1:0] stat_frames_good,
  output logic [COUNTER_WIDTH-1:0] stat_frames_bad,
  output logic [COUNTER_WIDTH-1:0] stat_overflow,
  output logic                     busy
);
  localparam int SYMS = 8 / MII_WIDTH;
  localparam int SW   = $clog2(SYMS);
  localparam int PW   = 8 - MII_WIDTH;
  localparam int BW   = $clog2(MAX_FRAME_BYTES + 1);
  localparam int IW   = MII_WIDTH + 3;

  if (MII_WIDTH != 4 && MII_WIDTH != 2) begin : g_bad_width
    $error("MII_WIDTH must be 4 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  logic [SYNC_STAGES-1:0][IW-1:0] sync_q;
  logic [IW-1:0]        rx_s;
  logic                 s_clk;
  logic                 s_dv;
  logic                 s_er;
  logic [MII_WIDTH-1:0] s_sym;
  logic                 clk_d;
  logic                 sample;

  state_t         state_q, state_n;
  logic [PW-1:0]  part_q, part_n;
  logic [SW-1:0]  scnt_q, scnt_n;
  logic [BW-1:0]  bcnt_q, bcnt_n;
  logic           ferr_q, ferr_n;
  logic [7:0]     held_q, held_n;
  logic           held_v_q, held_v_n;
  logic           fpend_q, fpend_n;
  logic           abort_q, abort_n;

  logic [7:0] assembled;
  logic       byte_done;
  logic       out_free;
  logic       can_mv;
  logic       eof_err;
  logic       ld_abort;
  logic       mv;
  logic       mv_first;
  logic       mv_last;
  logic       mv_err;
  logic       inc_good;
  logic       inc_bad;
  logic       inc_ovf;

  // all PHY inputs share one chain so dv/er/data stay aligned
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      clk_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mii_rx_clock,
                 mii_rx_data_valid, mii_rx_error, mii_rx_data};
      clk_d  <= s_clk;
    end
  end

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign s_clk     = rx_s[IW-1];
  assign s_dv      = rx_s[IW-2];
  assign s_er      = rx_s[IW-3];
  assign s_sym     = rx_s[MII_WIDTH-1:0];
  assign sample    = s_clk & ~clk_d;
  assign assembled = {s_sym, part_q};
  assign byte_done = (scnt_q == SW'(SYMS - 1));
  assign out_free  = ~out_valid | out_ready;
  assign can_mv    = out_free & ~abort_q;
  assign ld_abort  = abort_q & out_free;
  assign eof_err   = ferr_q | (scnt_q != '0)
                   | (int'(bcnt_q) < MIN_FRAME_BYTES);
  assign busy      = (state_q == S_PREAMBLE) | (state_q == S_DATA)
                   | (state_q == S_DROP);

  // next-state, assembly and holding-register moves
  always_comb begin
    state_n  = state_q;
    part_n   = part_q;
    scnt_n   = scnt_q;
    bcnt_n   = bcnt_q;
    ferr_n   = ferr_q;
    held_n   = held_q;
    held_v_n = held_v_q;
    fpend_n  = fpend_q;
    abort_n  = abort_q & ~out_free;
    mv       = 1'b0;
    mv_first = 1'b0;
    mv_last  = 1'b0;
    mv_err   = 1'b0;
    inc_good = 1'b0;
    inc_bad  = 1'b0;
    inc_ovf  = 1'b0;
    if (sample) begin
      unique case (state_q)
        S_WAIT_IDLE: begin
          if (!s_dv) state_n = S_IDLE;
        end
        S_IDLE: begin
          if (s_dv) begin
            state_n = S_PREAMBLE;
            part_n  = assembled[7:MII_WIDTH];
            scnt_n  = SW'(1);
          end
        end
        S_PREAMBLE: begin
          if (!s_dv) begin
            state_n = S_DROP;
            inc_bad = 1'b1;
          end else begin
            part_n = assembled[7:MII_WIDTH];
            if (!byte_done) begin
              scnt_n = scnt_q + SW'(1);
            end else begin
              scnt_n = '0;
              if (assembled == 8'hD5) begin
                state_n  = S_DATA;
                bcnt_n   = '0;
                ferr_n   = 1'b0;
                held_v_n = 1'b0;
                fpend_n  = 1'b1;
              end else if (assembled != 8'h55) begin
                state_n = S_DROP;
                inc_bad = 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (!s_dv) begin
            state_n  = S_IDLE;
            held_v_n = 1'b0;
            if (!held_v_q) begin
              inc_bad = 1'b1;
            end else if (!can_mv) begin
              state_n = S_DROP;
              inc_ovf = 1'b1;
              if (!fpend_q) abort_n = 1'b1;
            end else begin
              mv       = 1'b1;
              mv_first = fpend_q;
              mv_last  = 1'b1;
              mv_err   = eof_err;
              inc_good = ~eof_err;
              inc_bad  = eof_err;
            end
          end else begin
            if (s_er) ferr_n = 1'b1;
            part_n = assembled[7:MII_WIDTH];
            if (!byte_done) begin
              scnt_n = scnt_q + SW'(1);
            end else if (bcnt_q == BW'(MAX_FRAME_BYTES)) begin
              scnt_n   = '0;
              state_n  = S_DROP;
              held_v_n = 1'b0;
              if (!can_mv) begin
                inc_ovf = 1'b1;
                if (!fpend_q) abort_n = 1'b1;
              end else begin
                mv       = 1'b1;
                mv_first = fpend_q;
                mv_last  = 1'b1;
                mv_err   = 1'b1;
                inc_bad  = 1'b1;
              end
            end else begin
              scnt_n   = '0;
              bcnt_n   = bcnt_q + BW'(1);
              held_n   = assembled;
              held_v_n = 1'b1;
              if (held_v_q) begin
                if (!can_mv) begin
                  state_n  = S_DROP;
                  held_v_n = 1'b0;
                  inc_ovf  = 1'b1;
                  if (!fpend_q) abort_n = 1'b1;
                end else begin
                  mv       = 1'b1;
                  mv_first = fpend_q;
                  fpend_n  = 1'b0;
                end
              end
            end
          end
        end
        S_DROP: begin
          if (!s_dv) state_n = S_IDLE;
        end
        default: state_n = S_WAIT_IDLE;
      endcase
    end
  end

  // frame state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_WAIT_IDLE;
      part_q   <= '0;
      scnt_q   <= '0;
      bcnt_q   <= '0;
      ferr_q   <= 1'b0;
      held_q   <= '0;
      held_v_q <= 1'b0;
      fpend_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      part_q   <= part_n;
      scnt_q   <= scnt_n;
      bcnt_q   <= bcnt_n;
      ferr_q   <= ferr_n;
      held_q   <= held_n;
      held_v_q <= held_v_n;
      fpend_q  <= fpend_n;
      abort_q  <= abort_n;
    end
  end

  // single-entry output register; a stalled beat never changes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_error <= 1'b0;
    end else if (mv) begin
      out_valid <= 1'b1;
      out_data  <= held_q;
      out_first <= mv_first;
      out_last  <= mv_last;
      out_error <= mv_err;
    end else if (ld_abort) begin
      out_valid <= 1'b1;
      out_data  <= 8'h00;
      out_first <= 1'b0;
      out_last  <= 1'b1;
      out_error <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // saturating status counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_frames_good <= '0;
      stat_frames_bad  <= '0;
      stat_overflow    <= '0;
    end else begin
      if (inc_good && !(&stat_frames_good))
        stat_frames_good <= stat_frames_good + COUNTER_WIDTH'(1);
      if (inc_bad && !(&stat_frames_bad))
        stat_frames_bad <= stat_frames_bad + COUNTER_WIDTH'(1);
      if (inc_ovf && !(&stat_overflow))
        stat_overflow <= stat_overflow + COUNTER_WIDTH'(1);
    end
  end

endmodule
